// File: rtl/ccd_pkg.sv
// Shared types and default geometry for the CCD edge-measurement stage.
package ccd_pkg;

   localparam int DEF_NUM_PIX   = 3648;
   localparam int DEF_DUMMY_PIX = 32;
   localparam int DEF_ADC_W     = 8;
   localparam int DEF_IDX_W     = 12;

   typedef logic [DEF_IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SKIP   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_REPORT = 2'd3
   } ccd_state_t;

endpackage

// File: rtl/ccd_median3.sv
// Streaming 3-tap median. On each accepted pixel i it emits the filtered value of pixel i-1;
// on the last pixel it also emits that pixel itself (its missing right neighbour is itself).
module ccd_median3 #(
   parameter int ADC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             first_i,
   input  logic             last_i,
   input  logic [ADC_W-1:0] data_i,
   output logic             mid_valid_o,
   output logic [ADC_W-1:0] mid_data_o,
   output logic             tail_valid_o,
   output logic [ADC_W-1:0] tail_data_o
);

   logic [ADC_W-1:0] prev_q;
   logic [ADC_W-1:0] prev2_q;
   logic             prev_first_q;
   logic [ADC_W-1:0] left;

   function automatic logic [ADC_W-1:0] median3(input logic [ADC_W-1:0] a,
                                                input logic [ADC_W-1:0] b,
                                                input logic [ADC_W-1:0] c);
      logic [ADC_W-1:0] lo;
      logic [ADC_W-1:0] hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (c <= lo)      return lo;
      else if (c >= hi) return hi;
      else              return c;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q       <= '0;
         prev2_q      <= '0;
         prev_first_q <= 1'b0;
      end else if (valid_i) begin
         prev2_q      <= prev_q;
         prev_q       <= data_i;
         prev_first_q <= first_i;
      end
   end

   // Index 0 has no left neighbour, so it stands in for itself.
   assign left         = prev_first_q ? prev_q : prev2_q;
   assign mid_valid_o  = valid_i && !first_i;
   assign mid_data_o   = median3(left, prev_q, data_i);
   assign tail_valid_o = valid_i && last_i;
   assign tail_data_o  = data_i;

endmodule

// File: rtl/ccd_edge_measure.sv
// Shadow edge/width measurement on one CCD line framed by sh_pulse.
// Optional CCD_MEDIAN3_EN inserts a 3-tap median filter ahead of the threshold.
module ccd_edge_measure
   import ccd_pkg::*;
#(
   parameter int NUM_PIX   = DEF_NUM_PIX,
   parameter int DUMMY_PIX = DEF_DUMMY_PIX,
   parameter int ADC_W     = DEF_ADC_W,
   parameter int IDX_W     = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sh_pulse,
   input  logic             pix_valid,
   input  logic [ADC_W-1:0] pix_data,
   input  logic [ADC_W-1:0] threshold,
   input  logic [IDX_W-1:0] dim_min,
   input  logic [IDX_W-1:0] dim_max,
   output logic             meas_valid,
   output logic [IDX_W-1:0] edge_first,
   output logic [IDX_W-1:0] edge_last,
   output logic [IDX_W-1:0] width,
   output logic             no_part,
   output logic             part_ok,
   output logic             frame_err
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PIX - 1);
   localparam logic [IDX_W-1:0] SKIP_LAST = (DUMMY_PIX > 0) ? IDX_W'(DUMMY_PIX - 1) : '0;

   ccd_state_t       state_q, state_d;
   logic [IDX_W-1:0] skip_q, skip_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             found_q, found_d;
   logic [IDX_W-1:0] first_q, first_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic             err_pend_q, err_pend_d;

   logic             meas_valid_q, meas_valid_d;
   logic [IDX_W-1:0] edge_first_q, edge_first_d;
   logic [IDX_W-1:0] edge_last_q, edge_last_d;
   logic [IDX_W-1:0] width_q, width_d;
   logic             no_part_q, no_part_d;
   logic             part_ok_q, part_ok_d;
   logic             frame_err_q, frame_err_d;

   logic             start_frame;
   logic             report;
   logic             ev_a_dark;
   logic             ev_b_dark;

`ifdef CCD_MEDIAN3_EN
   logic             med_valid;
   logic             mid_valid;
   logic [ADC_W-1:0] mid_data;
   logic             tail_valid;
   logic [ADC_W-1:0] tail_data;

   assign med_valid = (state_q == ST_ACTIVE) && pix_valid && !sh_pulse;

   ccd_median3 #(.ADC_W(ADC_W)) u_median (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (med_valid),
      .first_i      (idx_q == '0),
      .last_i       (idx_q == LAST_IDX),
      .data_i       (pix_data),
      .mid_valid_o  (mid_valid),
      .mid_data_o   (mid_data),
      .tail_valid_o (tail_valid),
      .tail_data_o  (tail_data)
   );

   // Event A refers to the previous index (filter delay), event B to the current one.
   assign ev_a_dark = mid_valid && (mid_data < threshold);
   assign ev_b_dark = tail_valid && (tail_data < threshold);
`else
   assign ev_a_dark = 1'b0;
   assign ev_b_dark = pix_data < threshold;
`endif

   always_comb begin
      state_d      = state_q;
      skip_d       = skip_q;
      idx_d        = idx_q;
      found_d      = found_q;
      first_d      = first_q;
      last_d       = last_q;
      err_pend_d   = err_pend_q;
      meas_valid_d = 1'b0;
      edge_first_d = edge_first_q;
      edge_last_d  = edge_last_q;
      width_d      = width_q;
      no_part_d    = no_part_q;
      part_ok_d    = part_ok_q;
      frame_err_d  = frame_err_q;
      start_frame  = 1'b0;
      report       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sh_pulse) start_frame = 1'b1;
         end
         ST_SKIP: begin
            if (sh_pulse) begin
               start_frame = 1'b1;
               err_pend_d  = 1'b1;
            end else if (pix_valid) begin
               if (skip_q == SKIP_LAST) begin
                  state_d = ST_ACTIVE;
                  idx_d   = '0;
               end else begin
                  skip_d = skip_q + 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            if (sh_pulse) begin
               start_frame = 1'b1;
               err_pend_d  = 1'b1;
            end else if (pix_valid) begin
               if (ev_a_dark) begin
                  if (!found_d) first_d = idx_q - 1'b1;
                  found_d = 1'b1;
                  last_d  = idx_q - 1'b1;
               end
               if (ev_b_dark) begin
                  if (!found_d) first_d = idx_q;
                  found_d = 1'b1;
                  last_d  = idx_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_d = ST_REPORT;
                  report  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_REPORT: begin
            if (sh_pulse) start_frame = 1'b1;
            else          state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_frame) begin
         state_d = (DUMMY_PIX == 0) ? ST_ACTIVE : ST_SKIP;
         skip_d  = '0;
         idx_d   = '0;
         found_d = 1'b0;
         first_d = '0;
         last_d  = '0;
      end

      // Results are registered on the last pixel's edge so they appear with meas_valid.
      if (report) begin
         meas_valid_d = 1'b1;
         no_part_d    = !found_d;
         edge_first_d = found_d ? first_d : '0;
         edge_last_d  = found_d ? last_d : '0;
         width_d      = found_d ? (last_d - first_d + 1'b1) : '0;
         part_ok_d    = found_d && (width_d >= dim_min) && (width_d <= dim_max);
         frame_err_d  = err_pend_q;
         err_pend_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         skip_q       <= '0;
         idx_q        <= '0;
         found_q      <= 1'b0;
         first_q      <= '0;
         last_q       <= '0;
         err_pend_q   <= 1'b0;
         meas_valid_q <= 1'b0;
         edge_first_q <= '0;
         edge_last_q  <= '0;
         width_q      <= '0;
         no_part_q    <= 1'b0;
         part_ok_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         skip_q       <= skip_d;
         idx_q        <= idx_d;
         found_q      <= found_d;
         first_q      <= first_d;
         last_q       <= last_d;
         err_pend_q   <= err_pend_d;
         meas_valid_q <= meas_valid_d;
         edge_first_q <= edge_first_d;
         edge_last_q  <= edge_last_d;
         width_q      <= width_d;
         no_part_q    <= no_part_d;
         part_ok_q    <= part_ok_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign meas_valid = meas_valid_q;
   assign edge_first = edge_first_q;
   assign edge_last  = edge_last_q;
   assign width      = width_q;
   assign no_part    = no_part_q;
   assign part_ok    = part_ok_q;
   assign frame_err  = frame_err_q;

endmodule
